// File: rtl/seq_detect_pkg.sv
// Shared constants and mode encodings for the parametrised serial sequence detector.
package seq_detect_pkg;

  localparam int unsigned PAT_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  localparam int unsigned MODE_MEALY = 0;
  localparam int unsigned MODE_MOORE = 1;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } overlap_e;

endpackage

// File: rtl/seq_window.sv
// Shift window of the last PAT_W-1 accepted bits, saturating fill counter and
// combinational pattern compare against the incoming bit.
module seq_window
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W   = PAT_W_DEF,
  parameter int unsigned OVERLAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_q,
  output logic             hit_c
);

  localparam int unsigned WIN_W  = PAT_W - 1;
  localparam int unsigned FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam overlap_e OVL_MODE = (OVERLAP != 0) ? OVL_ON : OVL_OFF;

  logic [WIN_W-1:0]  window;
  logic [FILL_W-1:0] fill;

  // A match needs a full window of history plus the current accepted bit.
  assign hit_c = din_vld & ~pat_ld & (fill == FILL_MAX) & ({window, din} == pat_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window <= '0;
      fill   <= '0;
    end else if (pat_ld) begin
      fill <= '0;
    end else if (din_vld) begin
      window <= WIN_W'({window, din});
      if (hit_c && (OVL_MODE == OVL_OFF)) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector: runtime-loadable pattern, Mealy/Moore
// flag timing and optional saturating match counter (enabled by SEQDET_CNT_EN).
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b0101),
  parameter int unsigned      OVERLAP = 1,
  parameter int unsigned      MOORE   = MODE_MEALY,
  parameter int unsigned      CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  output logic             flag
`ifdef SEQDET_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  logic [PAT_W-1:0] pat_q;
  logic             hit_c;

  if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1) begin : g_param_chk
    $error("seq_detect_param: PAT_W must be 2..32 and CNT_W at least 1");
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= PAT_RST;
    end else if (pat_ld) begin
      pat_q <= pat_in;
    end
  end

  seq_window #(
    .PAT_W   (PAT_W),
    .OVERLAP (OVERLAP)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_vld (din_vld),
    .pat_ld  (pat_ld),
    .pat_q   (pat_q),
    .hit_c   (hit_c)
  );

  // Moore delays the hit by one edge; a pending flag is dropped by reset.
  if (MOORE == MODE_MOORE) begin : g_moore
    logic flag_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        flag_q <= 1'b0;
      end else begin
        flag_q <= hit_c;
      end
    end
    assign flag = flag_q;
  end else begin : g_mealy
    assign flag = hit_c;
  end

`ifdef SEQDET_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
    end else if (pat_ld) begin
      match_cnt <= '0;
    end else if (hit_c && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: overlapping Mealy, non-overlapping Mealy and
// Moore instances share one stimulus stream; counters checked when SEQDET_CNT_EN is set.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_vld;
  logic       pat_ld;
  logic [3:0] pat_in;
  logic       flag_ov, flag_nov, flag_mo;
`ifdef SEQDET_CNT_EN
  logic       flag_sat;
  logic [7:0] cnt_ov, cnt_nov, cnt_mo;
  logic [1:0] cnt_sat;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.OVERLAP(1), .MOORE(0)) u_ov (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .pat_ld(pat_ld),
    .pat_in(pat_in), .flag(flag_ov)
`ifdef SEQDET_CNT_EN
    , .match_cnt(cnt_ov)
`endif
  );

  seq_detect_param #(.OVERLAP(0), .MOORE(0)) u_nov (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .pat_ld(pat_ld),
    .pat_in(pat_in), .flag(flag_nov)
`ifdef SEQDET_CNT_EN
    , .match_cnt(cnt_nov)
`endif
  );

  seq_detect_param #(.OVERLAP(1), .MOORE(1)) u_mo (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .pat_ld(pat_ld),
    .pat_in(pat_in), .flag(flag_mo)
`ifdef SEQDET_CNT_EN
    , .match_cnt(cnt_mo)
`endif
  );

`ifdef SEQDET_CNT_EN
  seq_detect_param #(.OVERLAP(1), .MOORE(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .pat_ld(pat_ld),
    .pat_in(pat_in), .flag(flag_sat), .match_cnt(cnt_sat)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply n steps MSB-first; flags sampled mid-low-phase, before the accepting edge.
  task automatic run_seq(input string tag, input int n, input logic [15:0] bits,
                         input logic [15:0] vlds, input logic [15:0] e_ov,
                         input logic [15:0] e_nov, input logic [15:0] e_mo);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      din     = bits[i];
      din_vld = vlds[i];
      pat_ld  = 1'b0;
      #2;
      chk($sformatf("%s_ov_s%0d", tag, n - i), 32'(flag_ov), 32'(e_ov[i]));
      chk($sformatf("%s_nov_s%0d", tag, n - i), 32'(flag_nov), 32'(e_nov[i]));
      chk($sformatf("%s_mo_s%0d", tag, n - i), 32'(flag_mo), 32'(e_mo[i]));
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst     = 1'b0;
    din_vld = 1'b0;
    pat_ld  = 1'b0;
    @(negedge clk);
    chk({tag, "_rst_ov"}, 32'(flag_ov), 32'd0);
    chk({tag, "_rst_mo"}, 32'(flag_mo), 32'd0);
`ifdef SEQDET_CNT_EN
    chk({tag, "_rst_cnt"}, 32'(cnt_ov), 32'd0);
`endif
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    din     = 1'b0;
    din_vld = 1'b0;
    pat_ld  = 1'b0;
    pat_in  = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("init_ov", 32'(flag_ov), 32'd0);
    chk("init_nov", 32'(flag_nov), 32'd0);
    chk("init_mo", 32'(flag_mo), 32'd0);
`ifdef SEQDET_CNT_EN
    chk("init_cnt", 32'(cnt_ov), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // 0101010 then idle: overlap hits at bits 4 and 6, non-overlap only at 4.
    run_seq("ovl", 8, 16'b0101_0100, 16'b1111_1110,
            16'b0001_0100, 16'b0001_0000, 16'b0000_1010);
`ifdef SEQDET_CNT_EN
    chk("ovl_cnt_ov", 32'(cnt_ov), 32'd2);
    chk("ovl_cnt_nov", 32'(cnt_nov), 32'd1);
`endif

    // Accepted 0,1,0; invalid bits 1,0,1 must not match; then accepted 1 matches.
    do_reset("gap");
    run_seq("gap", 8, 16'b0101_0110, 16'b1110_0010,
            16'b0000_0010, 16'b0000_0010, 16'b0000_0001);

    // Partial 0,1,0 discarded by reset; 1 then 0,1,0,1 matches on the last bit.
    do_reset("mid");
    run_seq("mid_pre", 3, 16'b010, 16'b111, 16'b000, 16'b000, 16'b000);
    do_reset("mid");
    run_seq("mid", 6, 16'b10_1010, 16'b11_1110,
            16'b00_0010, 16'b00_0010, 16'b00_0001);

    // Moore flag raised after the edge, then killed asynchronously by reset.
    do_reset("pend");
    run_seq("pend", 4, 16'b0101, 16'b1111, 16'b0001, 16'b0001, 16'b0000);
    @(posedge clk);
    #1;
    chk("pend_mo_high", 32'(flag_mo), 32'd1);
    rst = 1'b0;
    #1;
    chk("pend_mo_cleared", 32'(flag_mo), 32'd0);
    chk("pend_ov_in_rst", 32'(flag_ov), 32'd0);
    @(negedge clk);
    din_vld = 1'b0;
    rst     = 1'b1;
    run_seq("pend_post", 2, 16'b00, 16'b00, 16'b00, 16'b00, 16'b00);

    // Load 1100 in a cycle that would otherwise match 0101; load wins.
    do_reset("ld");
    run_seq("ld_pre", 3, 16'b010, 16'b111, 16'b000, 16'b000, 16'b000);
    @(negedge clk);
    din     = 1'b1;
    din_vld = 1'b1;
    pat_ld  = 1'b1;
    pat_in  = 4'b1100;
    #2;
    chk("ld_ov_suppressed", 32'(flag_ov), 32'd0);
    chk("ld_nov_suppressed", 32'(flag_nov), 32'd0);
    run_seq("ld", 5, 16'b1_1000, 16'b1_1110, 16'b0_0010, 16'b0_0010, 16'b0_0001);
`ifdef SEQDET_CNT_EN
    chk("ld_cnt_ov", 32'(cnt_ov), 32'd1);
    chk("ld_cnt_sat", 32'(cnt_sat), 32'd1);
`endif

    // Four more 1100 matches: five total, 2-bit counter saturates at 3.
    run_seq("rep", 16, 16'hCCCC, 16'hFFFF, 16'h1111, 16'h1111, 16'h0888);
    run_seq("rep_tail", 1, 16'b0, 16'b0, 16'b0, 16'b0, 16'b1);
`ifdef SEQDET_CNT_EN
    chk("rep_cnt_ov", 32'(cnt_ov), 32'd5);
    chk("rep_cnt_sat", 32'(cnt_sat), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-sequence detector, the next generation of the fixed-pattern Mealy and Moore detectors.
- Pattern width is a parameter. Pattern value is runtime-loadable.
- Overlap/non-overlap and Mealy/Moore output timing are selected by parameter.
- Input takes a qualifying valid. Sits on a serial input stream and produces a one-cycle match flag for downstream control.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..32.
- PAT_RST, 4'b0101 (PAT_W bits), pattern loaded at reset.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history cleared after each match.
- MOORE, 0, 0 = Mealy (combinational flag in the cycle of the last bit); 1 = Moore (registered flag one cycle later).
- CNT_W, 8, match-counter width (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- din  in  1  serial data bit
- din_vld  in  1  din is sampled only when high
- pat_ld  in  1  load new pattern this cycle
- pat_in  in  PAT_W  pattern value to load
- flag  out  1  match indication, one cycle wide per match
- match_cnt  out  CNT_W  saturating match count (present only with SEQDET_CNT_EN)

Behaviour:
- Reset (rst low, asynchronous):
  - window (PAT_W-1 bits) = 0, fill = 0, pat_q = PAT_RST, flag register = 0, match_cnt = 0.
  - Mealy flag is 0 while rst is low.
- State:
  - window holds the last PAT_W-1 accepted bits, newest at LSB.
  - fill counts accepted bits, saturating at PAT_W-1; its width is clog2(PAT_W).
- hit (combinational) = din_vld & !pat_ld & (fill == PAT_W-1) & ({window, din} == pat_q).
- On a clock edge with pat_ld = 1 (load has priority):
  - pat_q <= pat_in, fill <= 0, window unchanged.
  - din is ignored that cycle and hit = 0.
- On a clock edge with din_vld = 1 and pat_ld = 0:
  - window <= {window[PAT_W-3:0], din}.
  - fill <= min(fill+1, PAT_W-1), except hit & !OVERLAP gives fill <= 0.
- din_vld = 0: window and fill hold. Gaps never break a partial match.
- Flag timing:
  - MOORE = 0: flag = hit, same cycle as the final pattern bit.
  - MOORE = 1: flag register <= hit; flag is high for exactly one cycle after the edge that accepted the final bit.
- Overlap vs non-overlap: OVERLAP = 1 allows a match on every accepted bit once fill is saturated. OVERLAP = 0 requires PAT_W fresh bits after each match.
- Reset mid-sequence discards all partial history. The first match after reset release needs PAT_W accepted bits.
- Moore flag pending at reset assertion is cleared and never emitted.
- Mealy: din changing while din_vld = 0 has no effect on flag.

Optional Feature:
- Macro SEQDET_CNT_EN.
- Defined:
  - match_cnt port exists; it increments on every hit and saturates at 2^CNT_W-1.
  - pat_ld also clears match_cnt to 0.
  - Reset value is 0.
- Undefined: no match_cnt port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package seq_detect_pkg holds:
  - default PAT_W / CNT_W constants
  - mode localparams MODE_MEALY = 0 and MODE_MOORE = 1
  - an enum for overlap mode
- One natural sub-module: seq_window, the shift window plus fill counter with hit compare.
- The top adds flag timing, pattern register and counter.

Test Plan:
- PAT_W = 4, pattern 0101, OVERLAP = 1, MOORE = 0; stream 0,1,0,1,0,1,0 with din_vld = 1 -> flag high in the cycles of bits 4 and 6 (1-based); 2 matches.
- Same stream, OVERLAP = 0 -> flag only at bit 4; bits 5-7 give no match; match_cnt = 1.
- MOORE = 1, stream 0101 -> flag high exactly one cycle after bit 4 is accepted; low otherwise.
- Stream 0,1,[din_vld = 0 for 3 cycles with din toggling],0,1 -> single match at the final 1; toggles are ignored.
- Drive 0,1,0, pulse rst low, release, then send 1 -> no flag. Then 0,1,0,1 -> flag on the 4th bit.
- pat_ld with pat_in = 1100 after bits 1,1 -> no flag. Then 1,1,0,0 -> match. With SEQDET_CNT_EN and CNT_W = 2, send 5 matches -> match_cnt = 3 (saturated).
